axi_stream_tp_check: RTL and testbench
======================================

Name: axi_stream_tp_check

Overview:
- Downstream consumer/checker for the AXI4-Stream video test-pattern source.
- Accepts the 8-bit video stream and recovers frame framing from TUSER[0] (start of frame) and TLAST (end of line).
- Checks pixel data against the pattern {line[3:0], pixel[3:0]} and checks line width and frame height against configured values.
- Reports frame and error counts plus sticky error flags to the control register block.

Parameters:
- DW, 8, TDATA width; the pattern occupies bits [7:0].
- CNT_W, 16, width of the frame and error counters (saturating).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous reset, active-low
- s_tdata  in  DW  stream pixel data
- s_tvalid  in  1  stream valid
- s_tready  out  1  stream ready
- s_tuser  in  1  TUSER[0], start of frame
- s_tlast  in  1  end of line
- chk_enable_i  in  1  run request; rising edge latches the configuration
- chk_width_i  in  11  expected pixels per line, >=1
- chk_height_i  in  11  expected lines per frame, >=1
- chk_frames_o  out  CNT_W  completed frames
- chk_errors_o  out  CNT_W  total error events
- chk_err_flags_o  out  4  sticky flags: [0] data, [1] short line, [2] long line, [3] unexpected SOF
- chk_busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: s_tready=1, counters=0, flags=0, chk_busy_o=0, state=IDLE.
- Transfers:
  - A beat is accepted when s_tvalid && s_tready.
  - s_tready is 1 in every state unless the optional feature drops it.
  - Status outputs are registered and update one clock after the accepted beat.
- Enable detection:
  - chk_enable_i passes through a 2-flop synchroniser; a rising edge is detected on the synchronised value.
  - On the rising edge, latch width/height and clear counters and flags.
- States:
  - IDLE: accept and discard all beats. On the enable rising edge, go to WAIT_SOF.
  - WAIT_SOF: discard beats until an accepted beat has s_tuser=1. That beat is checked as pixel 0 of line 0; go to ACTIVE.
  - ACTIVE: for each accepted beat, with pix/line as the counts before the beat:
    - Data check: if s_tdata[7:0] != {line[3:0], pix[3:0]}, raise the data error.
    - s_tlast with pix < width-1: short-line error; line++, pix=0.
    - s_tlast with pix == width-1: normal end of line; line++, pix=0.
    - No s_tlast with pix == width-1: long-line error is flagged on this beat. pix keeps counting, and no further long-line errors are raised until the next TLAST.
    - s_tuser=1 with (pix,line) != (0,0): unexpected-SOF error. The beat restarts the frame as pixel 0 of line 0, and the frame counter is not incremented.
    - TLAST on line height-1, short or normal: frames++, go to WAIT_SOF. A TUSER-marked beat in the same cycle as the previous beat's completion is handled by the next cycle's WAIT_SOF.
- Error counting:
  - Each beat adds at most 1 to chk_errors_o, even if several checks fail on the same beat.
  - Every flag that failed on that beat is still set.
- Saturation: counters stop at 2^CNT_W-1 and never wrap.
- Disable: synchronised enable low moves to IDLE on the next clock from any state. Counters and flags hold their values for readback.
- Mid-frame reset: everything returns to reset values. The partial frame is dropped, and after re-enable the checker waits for a fresh SOF.
- Arithmetic: pix and line are 11 bits; comparisons use width-1 and height-1 computed in 11 bits.

Optional Feature:
- Macro: AXIS_TP_CHK_BACKPRESSURE_EN.
- Defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances every clock.
  - In WAIT_SOF/ACTIVE, s_tready = lfsr[0] | lfsr[3], giving about 75% ready; IDLE stays at 1.
  - The purpose is to exercise TREADY handling in the upstream source.
- Undefined: s_tready is constant 1 and the LFSR logic is absent.

Decomposition:
- Package video_pkg:
  - chk_state_t enum: IDLE, WAIT_SOF, ACTIVE.
  - Error flag bit index constants ERR_DATA, ERR_SHORT, ERR_LONG, ERR_SOF.
  - PIX_W=11 constant.
  - The pattern function tp_pixel(line, pix), shared with the source.
- Sub-module sat_counter (CNT_W, inc, clr), instantiated for the frame and error counters.

Test Plan:
- Enable with width=4, height=3; send 2 correct frames of 12 beats each -> chk_frames_o=2, chk_errors_o=0, flags=4'b0000.
- Send a frame whose line 1 pixel 2 carries 8'h13 instead of 8'h12 -> chk_errors_o=1, flags=4'b0001, frames=1.
- Width=4; line 0 has TLAST on its 3rd beat -> short flag set, errors=1. Line 1 has no TLAST until its 6th beat -> long flag set, errors=2, and the extra beats add no further errors.
- Assert s_tuser on line 1 pixel 0 -> SOF flag set, frame restarts, frames unchanged; a following clean frame gives frames=1.
- Drop enable mid-frame, then re-enable -> counters clear. Beats before the next SOF are ignored and chk_errors_o stays 0.
- With AXIS_TP_CHK_BACKPRESSURE_EN defined, the same 2-frame stream with the source honouring TREADY -> frames=2, errors=0; s_tready is observed low at least once.

Source files
------------

// File: rtl/video_pkg.sv
// video_pkg: types and helpers shared by the video test-pattern source and checker.
//   chk_state_t : checker FSM states
//   ERR_*       : bit positions in the sticky error-flag vector
//   PIX_W       : width of the pixel/line counters and of the size configuration
//   tp_pixel()  : expected 8-bit pattern value for a given line/pixel position
package video_pkg;

  localparam int unsigned PIX_W = 11;

  localparam int unsigned ERR_DATA  = 0;
  localparam int unsigned ERR_SHORT = 1;
  localparam int unsigned ERR_LONG  = 2;
  localparam int unsigned ERR_SOF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    ACTIVE
  } chk_state_t;

  // Pattern is {line[3:0], pix[3:0]}; callers pass the low nibbles only.
  function automatic logic [7:0] tp_pixel(input logic [3:0] line, input logic [3:0] pix);
    return {line, pix};
  endfunction

endpackage

// File: rtl/axi_stream_tp_check_if.sv
// axi_stream_tp_check_if: 8-bit-pattern AXI4-Stream video link.
//   tdata  : pixel data (DW bits)
//   tvalid : beat valid
//   tready : sink ready
//   tuser  : TUSER[0], start of frame
//   tlast  : end of line
// Modports: master (source side), slave (sink side).
interface axi_stream_tp_check_if #(
  parameter int unsigned DW = 8
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
//   clk, rstn : clock, synchronous active-low reset
//   clr       : clear to zero (wins over inc)
//   inc       : add one, holding at all-ones
//   count     : current value
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/axi_stream_tp_check.sv
// axi_stream_tp_check: consumer/checker for the AXI4-Stream video test-pattern source.
// Recovers framing from TUSER (SOF) and TLAST (EOL), checks pixels against
// {line[3:0], pix[3:0]}, and checks line width / frame height.
//   clk, rstn        : clock, synchronous active-low reset
//   s                : stream sink (slave modport)
//   chk_enable_i     : run request (async; synchronised, rising edge latches config)
//   chk_width_i      : expected pixels per line (>=1)
//   chk_height_i     : expected lines per frame (>=1)
//   chk_frames_o     : completed frames (saturating)
//   chk_errors_o     : error beats (saturating, at most one per beat)
//   chk_err_flags_o  : sticky {sof, long, short, data}
//   chk_busy_o       : high outside IDLE
// Build option: AXIS_TP_CHK_BACKPRESSURE_EN drives pseudo-random TREADY from an LFSR
// while checking, to exercise upstream backpressure handling.
module axi_stream_tp_check
  import video_pkg::*;
#(
  parameter int unsigned DW    = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  axi_stream_tp_check_if.slave s,
  input  logic                 chk_enable_i,
  input  logic [PIX_W-1:0]     chk_width_i,
  input  logic [PIX_W-1:0]     chk_height_i,
  output logic [CNT_W-1:0]     chk_frames_o,
  output logic [CNT_W-1:0]     chk_errors_o,
  output logic [3:0]           chk_err_flags_o,
  output logic                 chk_busy_o
);

  chk_state_t       state_q, state_d;
  logic             en_meta_q, en_sync_q, en_prev_q, en_rise;
  logic [PIX_W-1:0] width_q, height_q, wm1, hm1;
  logic [PIX_W-1:0] pix_q, pix_d, line_q, line_d, eff_pix, eff_line;
  logic             long_seen_q, long_seen_d, long_seen_eff;
  logic [3:0]       flags_q, beat_flags;
  logic [DW-1:0]    tdata;
  logic             beat, check_beat, in_frame, frame_done;

  assign tdata = s.tdata;

  // Enable synchroniser and rising-edge detect on the synchronised value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      en_meta_q <= 1'b0;
      en_sync_q <= 1'b0;
      en_prev_q <= 1'b0;
    end else begin
      en_meta_q <= chk_enable_i;
      en_sync_q <= en_meta_q;
      en_prev_q <= en_sync_q;
    end
  end

  assign en_rise = en_sync_q & ~en_prev_q;
  assign wm1     = width_q - PIX_W'(1);
  assign hm1     = height_q - PIX_W'(1);
  assign beat    = s.tvalid & s.tready;

  // Beat checking. A TUSER beat (in WAIT_SOF, or a mid-frame restart in ACTIVE) is
  // evaluated as pixel 0 of line 0, so the effective position collapses to zero.
  always_comb begin
    check_beat    = beat && (((state_q == WAIT_SOF) && s.tuser) || (state_q == ACTIVE));
    in_frame      = (state_q == ACTIVE) && !s.tuser;
    eff_pix       = in_frame ? pix_q : '0;
    eff_line      = in_frame ? line_q : '0;
    long_seen_eff = in_frame ? long_seen_q : 1'b0;
    beat_flags    = '0;
    frame_done    = 1'b0;
    if (check_beat) begin
      beat_flags[ERR_DATA]  = tdata[7:0] != tp_pixel(eff_line[3:0], eff_pix[3:0]);
      beat_flags[ERR_SHORT] = s.tlast && (eff_pix < wm1);
      beat_flags[ERR_LONG]  = !s.tlast && (eff_pix == wm1) && !long_seen_eff;
      beat_flags[ERR_SOF]   = (state_q == ACTIVE) && s.tuser &&
                              ((pix_q != '0) || (line_q != '0));
      frame_done            = s.tlast && (eff_line == hm1);
    end
  end

  always_comb begin
    pix_d       = pix_q;
    line_d      = line_q;
    long_seen_d = long_seen_q;
    if (en_rise) begin
      pix_d       = '0;
      line_d      = '0;
      long_seen_d = 1'b0;
    end else if (check_beat) begin
      if (s.tlast) begin
        pix_d       = '0;
        line_d      = frame_done ? '0 : eff_line + PIX_W'(1);
        long_seen_d = 1'b0;
      end else begin
        pix_d       = eff_pix + PIX_W'(1);
        line_d      = eff_line;
        long_seen_d = long_seen_eff | beat_flags[ERR_LONG];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      width_q     <= PIX_W'(1);
      height_q    <= PIX_W'(1);
      pix_q       <= '0;
      line_q      <= '0;
      long_seen_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      if (en_rise) begin
        width_q  <= chk_width_i;
        height_q <= chk_height_i;
      end
      pix_q       <= pix_d;
      line_q      <= line_d;
      long_seen_q <= long_seen_d;
      flags_q     <= en_rise ? 4'b0000 : (flags_q | beat_flags);
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state; a low synchronised enable always wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (en_rise) state_d = WAIT_SOF;
      WAIT_SOF: if (check_beat) state_d = frame_done ? WAIT_SOF : ACTIVE;
      ACTIVE:   if (frame_done) state_d = WAIT_SOF;
      default:  state_d = IDLE;
    endcase
    if (!en_sync_q) state_d = IDLE;
  end

`ifdef AXIS_TP_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end
`endif

  // FSM: outputs
  always_comb begin
    chk_busy_o = (state_q != IDLE);
`ifdef AXIS_TP_CHK_BACKPRESSURE_EN
    s.tready   = (state_q == IDLE) ? 1'b1 : (lfsr_q[0] | lfsr_q[3]);
`else
    s.tready   = 1'b1;
`endif
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (en_rise),
    .inc   (frame_done),
    .count (chk_frames_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_error_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (en_rise),
    .inc   (|beat_flags),
    .count (chk_errors_o)
  );

  assign chk_err_flags_o = flags_q;

endmodule

// File: tb/tb_axi_stream_tp_check.sv
// Self-checking bench for axi_stream_tp_check: width=4, height=3 directed scenarios.
module tb_axi_stream_tp_check;

  logic        clk;
  logic        rstn;
  logic        chk_enable;
  logic [10:0] chk_width;
  logic [10:0] chk_height;
  logic [15:0] chk_frames;
  logic [15:0] chk_errors;
  logic [3:0]  chk_flags;
  logic        chk_busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit ready_low_seen = 1'b0;

  axi_stream_tp_check_if #(.DW(8)) s_if ();

  axi_stream_tp_check #(
    .DW    (8),
    .CNT_W (16)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .s               (s_if),
    .chk_enable_i    (chk_enable),
    .chk_width_i     (chk_width),
    .chk_height_i    (chk_height),
    .chk_frames_o    (chk_frames),
    .chk_errors_o    (chk_errors),
    .chk_err_flags_o (chk_flags),
    .chk_busy_o      (chk_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       user;
    logic       last;
    int         frames;
    int         errors;
    logic [3:0] flags;
  } vec_t;

  vec_t tbl[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one beat and hold it until the DUT accepts it (tready sampled mid-cycle).
  task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
    int waited = 0;
    @(negedge clk);
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && waited < 50) begin
      ready_low_seen = 1'b1;
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got tready=0 for %0d cycles expected acceptance", waited);
    end
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  // Full 4x3 frame; one pixel may be replaced by bad_data.
  task automatic send_frame(input int bad_line, input int bad_pix, input logic [7:0] bad_data);
    logic [7:0] d;
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 4; px++) begin
        d = {ln[3:0], px[3:0]};
        if (ln == bad_line && px == bad_pix) d = bad_data;
        send_beat(d, (ln == 0 && px == 0), (px == 3));
      end
    end
    @(negedge clk);
  endtask

  task automatic enable_chk();
    @(negedge clk);
    chk_enable = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_after_enable", 32'(chk_busy), 32'd1);
  endtask

  task automatic disable_chk();
    @(negedge clk);
    chk_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_after_disable", 32'(chk_busy), 32'd0);
  endtask

  initial begin
    // Short line (3rd beat), long line (TLAST on 6th beat), clean final line.
    tbl[0]  = '{8'h00, 1'b1, 1'b0, 0, 0, 4'b0000};
    tbl[1]  = '{8'h01, 1'b0, 1'b0, 0, 0, 4'b0000};
    tbl[2]  = '{8'h02, 1'b0, 1'b1, 0, 1, 4'b0010};
    tbl[3]  = '{8'h10, 1'b0, 1'b0, 0, 1, 4'b0010};
    tbl[4]  = '{8'h11, 1'b0, 1'b0, 0, 1, 4'b0010};
    tbl[5]  = '{8'h12, 1'b0, 1'b0, 0, 1, 4'b0010};
    tbl[6]  = '{8'h13, 1'b0, 1'b0, 0, 2, 4'b0110};
    tbl[7]  = '{8'h14, 1'b0, 1'b0, 0, 2, 4'b0110};
    tbl[8]  = '{8'h15, 1'b0, 1'b1, 0, 2, 4'b0110};
    tbl[9]  = '{8'h20, 1'b0, 1'b0, 0, 2, 4'b0110};
    tbl[10] = '{8'h21, 1'b0, 1'b0, 0, 2, 4'b0110};
    tbl[11] = '{8'h22, 1'b0, 1'b0, 0, 2, 4'b0110};
    tbl[12] = '{8'h23, 1'b0, 1'b1, 1, 2, 4'b0110};

    rstn        = 1'b0;
    chk_enable  = 1'b0;
    chk_width   = 11'd4;
    chk_height  = 11'd3;
    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tuser  = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    check("rst_tready", 32'(s_if.tready), 32'd1);
    check("rst_frames", 32'(chk_frames), 32'd0);
    check("rst_errors", 32'(chk_errors), 32'd0);
    check("rst_flags", 32'(chk_flags), 32'd0);
    check("rst_busy", 32'(chk_busy), 32'd0);

    // Two clean frames.
    enable_chk();
    send_frame(-1, -1, 8'h00);
    check("clean_frames_1", 32'(chk_frames), 32'd1);
    send_frame(-1, -1, 8'h00);
    check("clean_frames", 32'(chk_frames), 32'd2);
    check("clean_errors", 32'(chk_errors), 32'd0);
    check("clean_flags", 32'(chk_flags), 32'd0);

    // Bad pixel on line 1 pixel 2.
    disable_chk();
    check("hold_frames", 32'(chk_frames), 32'd2);
    enable_chk();
    check("reenable_frames_clr", 32'(chk_frames), 32'd0);
    send_frame(1, 2, 8'h13);
    check("data_errors", 32'(chk_errors), 32'd1);
    check("data_flags", 32'(chk_flags), 32'd1);
    check("data_frames", 32'(chk_frames), 32'd1);

    // Short / long lines, checked beat by beat.
    disable_chk();
    enable_chk();
    for (int i = 0; i < 13; i++) begin
      send_beat(tbl[i].data, tbl[i].user, tbl[i].last);
      @(negedge clk);
      check($sformatf("tbl%0d_frames", i), 32'(chk_frames), 32'(tbl[i].frames));
      check($sformatf("tbl%0d_errors", i), 32'(chk_errors), 32'(tbl[i].errors));
      check($sformatf("tbl%0d_flags", i), 32'(chk_flags), 32'(tbl[i].flags));
    end

    // Unexpected SOF at line 1 pixel 0 restarts the frame.
    disable_chk();
    enable_chk();
    for (int px = 0; px < 4; px++) send_beat({4'h0, px[3:0]}, (px == 0), (px == 3));
    send_beat(8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("sof_errors", 32'(chk_errors), 32'd1);
    check("sof_flag", 32'(chk_flags[3]), 32'd1);
    check("sof_frames", 32'(chk_frames), 32'd0);
    for (int ln = 0; ln < 3; ln++) begin
      for (int px = 0; px < 4; px++) begin
        if (!(ln == 0 && px == 0)) send_beat({ln[3:0], px[3:0]}, 1'b0, (px == 3));
      end
    end
    @(negedge clk);
    check("sof_restart_frames", 32'(chk_frames), 32'd1);
    check("sof_restart_errors", 32'(chk_errors), 32'd1);

    // Disable mid-frame, then re-enable: counters clear, pre-SOF beats ignored.
    disable_chk();
    enable_chk();
    send_frame(0, 1, 8'hAA);
    check("mid_pre_errors", 32'(chk_errors), 32'd1);
    for (int px = 0; px < 4; px++) send_beat({4'h0, px[3:0]}, (px == 0), (px == 3));
    send_beat(8'h10, 1'b0, 1'b0);
    disable_chk();
    check("mid_hold_errors", 32'(chk_errors), 32'd1);
    check("mid_hold_frames", 32'(chk_frames), 32'd1);
    enable_chk();
    check("mid_clr_errors", 32'(chk_errors), 32'd0);
    check("mid_clr_frames", 32'(chk_frames), 32'd0);
    for (int i = 0; i < 3; i++) send_beat(8'hFF, 1'b0, (i == 2));
    @(negedge clk);
    check("mid_ignored_errors", 32'(chk_errors), 32'd0);
    send_frame(-1, -1, 8'h00);
    check("mid_clean_frames", 32'(chk_frames), 32'd1);
    check("mid_clean_errors", 32'(chk_errors), 32'd0);

    // Reset in the middle of a frame.
    for (int px = 0; px < 3; px++) send_beat({4'h0, px[3:0]}, (px == 0), 1'b0);
    @(negedge clk);
    rstn       = 1'b0;
    chk_enable = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("mrst_tready", 32'(s_if.tready), 32'd1);
    check("mrst_busy", 32'(chk_busy), 32'd0);
    check("mrst_frames", 32'(chk_frames), 32'd0);
    check("mrst_flags", 32'(chk_flags), 32'd0);
    enable_chk();
    send_beat(8'h03, 1'b0, 1'b1);
    send_frame(-1, -1, 8'h00);
    check("mrst_frames_after", 32'(chk_frames), 32'd1);
    check("mrst_errors_after", 32'(chk_errors), 32'd0);

`ifdef AXIS_TP_CHK_BACKPRESSURE_EN
    check("tready_low_seen", 32'(ready_low_seen), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
